// File: rtl/bpb_pkg.sv
// Shared types and the saturating-counter helper for the pattern history table update path.
`ifndef BPB_T
`define BPB_T 4
`endif

package bpb_pkg;

    typedef logic [1:0] ctr_t;

    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } sched_state_t;

    // Two-bit saturating step: never wraps past strongly taken or strongly not-taken.
    function automatic ctr_t sat_update(ctr_t c, logic taken);
        ctr_t r;
        if (taken) r = (c == 2'b11) ? c : c + 2'd1;
        else       r = (c == 2'b00) ? c : c - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/bpb_upd_fifo.sv
// Small synchronous FIFO holding {index, taken} updates; the caller never pushes when full or pops when empty.
module bpb_upd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    input  logic                           flush,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [WIDTH-1:0]               head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/bpb_update_sched.sv
// Sole writer of the branch predictor pattern history table: clear sweep after reset/flush,
// then a two-stage read-modify-write pipeline fed by a FIFO of resolved branch outcomes.
module bpb_update_sched
    import bpb_pkg::*;
#(
    parameter int   IWIDTH    = `BPB_T,
    parameter int   DEPTH     = 4,
    parameter ctr_t CLEAR_VAL = 2'b01
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           upd_valid,
    input  logic [IWIDTH-1:0]              upd_index,
    input  logic                           upd_taken,
    output logic                           upd_ready,
    input  logic                           flush_req,
    input  logic                           port_busy,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     pending,
    output logic [IWIDTH-1:0]              tbl_rd_index,
    input  logic [1:0]                     tbl_rd_data,
    output logic                           tbl_wr_en,
    output logic [IWIDTH-1:0]              tbl_wr_index,
    output logic [1:0]                     tbl_wr_data
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [IWIDTH-1:0] LAST = '1;

    sched_state_t      state;
    logic [IWIDTH-1:0] ptr;
    logic              w_valid;
    logic [IWIDTH-1:0] w_index;
    logic              w_taken;
    logic              fwd_hit;
    ctr_t              fwd_val;

    logic [IWIDTH:0]   head;
    logic [IWIDTH-1:0] head_index;
    logic [CW-1:0]     count;
    logic              run;
    logic              empty;
    logic              push;
    logic              pop;
    logic              w_fire;
    ctr_t              w_old;
    ctr_t              w_new;

    assign run        = (state == RUN);
    assign empty      = (count == '0);
    assign upd_ready  = run && !flush_req && (count < CW'(DEPTH));
    assign push       = upd_valid && upd_ready;
    assign pop        = run && !flush_req && !empty && !port_busy;
    assign w_fire     = run && w_valid && !flush_req;
    assign head_index = head[IWIDTH:1];

    bpb_upd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IWIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({upd_index, upd_taken}),
        .pop       (pop),
        .flush     (flush_req),
        .count     (count),
        .head      (head)
    );

    // The table returns the pre-write value on a same-cycle read/write, so a pending hit takes the forwarded value.
    assign w_old = fwd_hit ? fwd_val : tbl_rd_data;
    assign w_new = sat_update(w_old, w_taken);

    assign busy         = !run;
    assign pending      = count;
    assign tbl_rd_index = empty ? '0 : head_index;

    always_comb begin
        tbl_wr_en    = 1'b0;
        tbl_wr_index = '0;
        tbl_wr_data  = '0;
        if (!run) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = ptr;
            tbl_wr_data  = CLEAR_VAL;
        end else if (w_fire) begin
            tbl_wr_en    = 1'b1;
            tbl_wr_index = w_index;
            tbl_wr_data  = w_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= SWEEP;
            ptr     <= '0;
            w_valid <= 1'b0;
            w_index <= '0;
            w_taken <= 1'b0;
            fwd_hit <= 1'b0;
            fwd_val <= '0;
        end else begin
            case (state)
                SWEEP: begin
                    w_valid <= 1'b0;
                    fwd_hit <= 1'b0;
                    if (flush_req) begin
                        ptr <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST) state <= RUN;
                    end
                end
                RUN: begin
                    if (flush_req) begin
                        state   <= SWEEP;
                        ptr     <= '0;
                        w_valid <= 1'b0;
                        fwd_hit <= 1'b0;
                    end else begin
                        w_valid <= pop;
                        if (pop) begin
                            w_index <= head_index;
                            w_taken <= head[0];
                        end
                        fwd_hit <= pop && w_fire && (head_index == w_index);
                        fwd_val <= w_new;
                    end
                end
                default: state <= SWEEP;
            endcase
        end
    end

endmodule
